video_timing_gen: RTL and testbench

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

---
 rtl/video_timing_pkg.sv | 26 ++
 rtl/video_timing_gen.sv | 118 +++++++++++
 tb/tb_video_timing_gen.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/video_timing_pkg.sv
// Shared video mode constants (PAL 720x576@50) and timing helpers used by the
// timing generator and the HDMI encoder.
package video_timing_pkg;

    localparam int unsigned XW = 11;
    localparam int unsigned YW = 10;

    localparam int unsigned PAL_H_ACTIVE = 720;
    localparam int unsigned PAL_H_FP     = 12;
    localparam int unsigned PAL_H_SYNC   = 64;
    localparam int unsigned PAL_H_BP     = 68;
    localparam int unsigned PAL_H_TOTAL  = PAL_H_ACTIVE + PAL_H_FP + PAL_H_SYNC + PAL_H_BP;

    localparam int unsigned PAL_V_ACTIVE = 576;
    localparam int unsigned PAL_V_FP     = 5;
    localparam int unsigned PAL_V_SYNC   = 5;
    localparam int unsigned PAL_V_BP     = 39;
    localparam int unsigned PAL_V_TOTAL  = PAL_V_ACTIVE + PAL_V_FP + PAL_V_SYNC + PAL_V_BP;

    // True when pos lies in the half-open window [lo, lo+len).
    function automatic logic in_window(input int unsigned pos, input int unsigned lo,
                                       input int unsigned len);
        return (pos >= lo) && (pos < lo + len);
    endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Raster timing generator: free-running pixel/line counters with registered sync,
// data-enable and frame-start outputs, resynchronisable by a vreset edge.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = PAL_H_ACTIVE,
    parameter int unsigned H_FP     = PAL_H_FP,
    parameter int unsigned H_SYNC   = PAL_H_SYNC,
    parameter int unsigned H_BP     = PAL_H_BP,
    parameter int unsigned V_ACTIVE = PAL_V_ACTIVE,
    parameter int unsigned V_FP     = PAL_V_FP,
    parameter int unsigned V_SYNC   = PAL_V_SYNC,
    parameter int unsigned V_BP     = PAL_V_BP,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vreset,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          hs,
    output logic          vs,
    output logic          de,
    output logic          frame_start,
    output logic          locked
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] V_LAST = YW'(V_TOTAL - 1);

    typedef enum logic {StUnlocked, StLocked} lock_state_e;

    lock_state_e   state_q, state_d;
    logic [XW-1:0] hc_q, hc_d;
    logic [YW-1:0] vc_q, vc_d;
    logic          vreset_q;
    logic          vreset_edge;

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          de_q, de_d;
    logic          fs_q, fs_d;

    assign vreset_edge = vreset & ~vreset_q;

    // Counters; a resync edge overrides the increment and any wrap.
    always_comb begin
        hc_d = hc_q + 1'b1;
        vc_d = vc_q;
        if (hc_q == H_LAST) begin
            hc_d = '0;
            vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
        end
        if (vreset_edge) begin
            hc_d = '0;
            vc_d = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StUnlocked: if (vreset_edge) state_d = StLocked;
            StLocked:   state_d = StLocked;
            default:    state_d = StUnlocked;
        endcase
    end

    // Outputs decode the current counters and register them, keeping all aligned.
    always_comb begin
        x_d  = hc_q;
        y_d  = vc_q;
        de_d = in_window(32'(hc_q), 0, H_ACTIVE) && in_window(32'(vc_q), 0, V_ACTIVE);
        hs_d = in_window(32'(hc_q), H_ACTIVE + H_FP, H_SYNC) ? HS_POL : ~HS_POL;
        vs_d = in_window(32'(vc_q), V_ACTIVE + V_FP, V_SYNC) ? VS_POL : ~VS_POL;
        fs_d = (hc_q == '0) && (vc_q == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StUnlocked;
            hc_q     <= '0;
            vc_q     <= '0;
            vreset_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            hs_q     <= ~HS_POL;
            vs_q     <= ~VS_POL;
            de_q     <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            hc_q     <= hc_d;
            vc_q     <= vc_d;
            vreset_q <= vreset;
            x_q      <= x_d;
            y_q      <= y_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            de_q     <= de_d;
            fs_q     <= fs_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign de          = de_q;
    assign frame_start = fs_q;
    assign locked      = (state_q == StLocked);

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a reduced 25x13 raster (frame = 325 clocks),
// with a second instance built for active-high syncs.
module tb_video_timing_gen;

    localparam int unsigned TH_ACT = 16;
    localparam int unsigned TH_FP  = 2;
    localparam int unsigned TH_SY  = 4;
    localparam int unsigned TH_BP  = 3;
    localparam int unsigned TV_ACT = 8;
    localparam int unsigned TV_FP  = 1;
    localparam int unsigned TV_SY  = 2;
    localparam int unsigned TV_BP  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vreset = 1'b0;
    logic [10:0] x, x_p;
    logic [9:0]  y, y_p;
    logic        hs, vs, de, fs, locked;
    logic        hs_p, vs_p, de_p, fs_p, locked_p;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACTIVE(TH_ACT), .H_FP(TH_FP), .H_SYNC(TH_SY), .H_BP(TH_BP),
        .V_ACTIVE(TV_ACT), .V_FP(TV_FP), .V_SYNC(TV_SY), .V_BP(TV_BP),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .vreset(vreset), .x(x), .y(y), .hs(hs), .vs(vs),
        .de(de), .frame_start(fs), .locked(locked)
    );

    video_timing_gen #(
        .H_ACTIVE(TH_ACT), .H_FP(TH_FP), .H_SYNC(TH_SY), .H_BP(TH_BP),
        .V_ACTIVE(TV_ACT), .V_FP(TV_FP), .V_SYNC(TV_SY), .V_BP(TV_BP),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut_p (
        .clk(clk), .reset(reset), .vreset(vreset), .x(x_p), .y(y_p), .hs(hs_p), .vs(vs_p),
        .de(de_p), .frame_start(fs_p), .locked(locked_p)
    );

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned bad_x, bad_y, bad_de, bad_hs, bad_vs, bad_fs, bad_pol;
        int unsigned n_de, n_fs, n_hs, n_vs;
        int unsigned hs_fall0, hs_fall1, vs_fall0, vs_fall1;
        logic        prev_hs, prev_vs;
        int          p, ex, ey;
        logic        ede, ehs, evs;

        // Reset state
        repeat (3) tick();
        chk("rst_x", 32'(x), 0);
        chk("rst_y", 32'(y), 0);
        chk("rst_de", 32'(de), 0);
        chk("rst_fs", 32'(fs), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_hs", 32'(hs), 1);
        chk("rst_vs", 32'(vs), 1);
        chk("rst_hs_pol1", 32'(hs_p), 0);
        chk("rst_vs_pol1", 32'(vs_p), 0);

        // Two free-running frames; tick n shows raster index n-1
        reset = 1'b0;
        bad_x = 0; bad_y = 0; bad_de = 0; bad_hs = 0; bad_vs = 0; bad_fs = 0; bad_pol = 0;
        n_de = 0; n_fs = 0; n_hs = 0; n_vs = 0;
        hs_fall0 = 0; hs_fall1 = 0; vs_fall0 = 0; vs_fall1 = 0;
        prev_hs = 1'b1; prev_vs = 1'b1;
        for (int n = 1; n <= 650; n++) begin
            tick();
            p   = n - 1;
            ex  = p % 25;
            ey  = (p / 25) % 13;
            ede = (ex < 16) && (ey < 8);
            ehs = (ex >= 18) && (ex < 22);
            evs = (ey >= 9) && (ey < 11);
            if (32'(x) != 32'(ex)) bad_x++;
            if (32'(y) != 32'(ey)) bad_y++;
            if (de !== ede) bad_de++;
            if (hs !== !ehs) bad_hs++;
            if (vs !== !evs) bad_vs++;
            if (fs !== ((ex == 0) && (ey == 0))) bad_fs++;
            if ((hs_p !== ehs) || (vs_p !== evs) || (de_p !== ede)) bad_pol++;
            if (de) n_de++;
            if (fs) n_fs++;
            if (!hs) n_hs++;
            if (!vs) n_vs++;
            if (prev_hs && !hs) begin
                if (hs_fall0 == 0) hs_fall0 = n;
                else if (hs_fall1 == 0) hs_fall1 = n;
            end
            if (prev_vs && !vs) begin
                if (vs_fall0 == 0) vs_fall0 = n;
                else if (vs_fall1 == 0) vs_fall1 = n;
            end
            prev_hs = hs;
            prev_vs = vs;
        end
        chk("run_x", bad_x, 0);
        chk("run_y", bad_y, 0);
        chk("run_de", bad_de, 0);
        chk("run_hs", bad_hs, 0);
        chk("run_vs", bad_vs, 0);
        chk("run_fs", bad_fs, 0);
        chk("run_pol1", bad_pol, 0);
        chk("de_count", n_de, 256);
        chk("fs_count", n_fs, 2);
        chk("hs_active_count", n_hs, 104);
        chk("vs_active_count", n_vs, 100);
        chk("hs_first_fall", hs_fall0, 19);
        chk("hs_period", hs_fall1 - hs_fall0, 25);
        chk("vs_first_fall", vs_fall0, 226);
        chk("vs_period", vs_fall1 - vs_fall0, 325);

        // Resync pulse with counters at hc=10, vc=5
        repeat (135) tick();
        chk("pre_sync_x", 32'(x), 9);
        chk("pre_sync_locked", 32'(locked), 0);
        vreset = 1'b1;
        tick();
        chk("sync0_x", 32'(x), 10);
        chk("sync0_y", 32'(y), 5);
        chk("sync0_fs", 32'(fs), 0);
        chk("sync0_locked", 32'(locked), 1);
        vreset = 1'b0;
        tick();
        chk("sync1_x", 32'(x), 0);
        chk("sync1_y", 32'(y), 0);
        chk("sync1_fs", 32'(fs), 1);
        chk("sync1_locked", 32'(locked), 1);
        chk("sync1_locked_pol1", 32'(locked_p), 1);
        tick();
        chk("sync2_x", 32'(x), 1);
        chk("sync2_fs", 32'(fs), 0);

        // vreset held high for 2000 cycles starting at hc=11, vc=0
        repeat (9) tick();
        vreset = 1'b1;
        n_fs = 0;
        for (int k = 1; k <= 2000; k++) begin
            tick();
            if (fs) n_fs++;
        end
        chk("hold_fs_count", n_fs, 7);
        chk("hold_end_x", 32'(x), 23);
        chk("hold_end_y", 32'(y), 1);
        vreset = 1'b0;

        // vreset edge coinciding with the natural wrap at hc=24, vc=12
        repeat (275) tick();
        chk("prewrap_x", 32'(x), 23);
        chk("prewrap_y", 32'(y), 12);
        vreset = 1'b1;
        tick();
        chk("wrap0_fs", 32'(fs), 0);
        vreset = 1'b0;
        n_fs = 0;
        for (int k = 1; k <= 325; k++) begin
            tick();
            if (k == 1) begin
                chk("wrap1_x", 32'(x), 0);
                chk("wrap1_y", 32'(y), 0);
                chk("wrap1_fs", 32'(fs), 1);
            end
            if (fs) n_fs++;
        end
        chk("wrap_frame_fs_count", n_fs, 1);
        tick();
        chk("wrap_next_fs", 32'(fs), 1);
        chk("wrap_next_x", 32'(x), 0);

        // Reset mid-frame after lock, with a vreset pulse during reset
        repeat (100) tick();
        reset = 1'b1;
        vreset = 1'b1;
        tick();
        vreset = 1'b0;
        tick();
        chk("mid_rst_locked", 32'(locked), 0);
        chk("mid_rst_hs", 32'(hs), 1);
        chk("mid_rst_vs", 32'(vs), 1);
        chk("mid_rst_hs_pol1", 32'(hs_p), 0);
        chk("mid_rst_vs_pol1", 32'(vs_p), 0);
        chk("mid_rst_de", 32'(de), 0);
        chk("mid_rst_x", 32'(x), 0);
        reset = 1'b0;
        tick();
        chk("rel_x", 32'(x), 0);
        chk("rel_y", 32'(y), 0);
        chk("rel_fs", 32'(fs), 1);
        chk("rel_locked", 32'(locked), 0);
        tick();
        chk("rel2_x", 32'(x), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
